// File: rtl/control_estados_pkg.sv
// Shared definitions for the virtual-pet state controller: state codes,
// level widths, the level bundle and the candidate-state priority function.
package control_estados_pkg;

  localparam int unsigned ESTADO_W = 3;
  localparam int unsigned NIVEL_W  = 2;

  localparam logic [NIVEL_W-1:0] NIVEL_LLENO = 2'd3;
  localparam logic [NIVEL_W-1:0] NIVEL_BAJO  = 2'd1;
  localparam logic [NIVEL_W-1:0] NIVEL_CERO  = 2'd0;

  typedef enum logic [ESTADO_W-1:0] {
    FELIZ      = 3'd0,
    TRISTE     = 3'd1,
    CANSADO    = 3'd2,
    HAMBRIENTO = 3'd3,
    ENFERMO    = 3'd4,
    MUERTO     = 3'd5
  } estado_t;

  // The four need levels coming from the mode counters.
  typedef struct packed {
    logic [NIVEL_W-1:0] animo;
    logic [NIVEL_W-1:0] energia;
    logic [NIVEL_W-1:0] descanso;
    logic [NIVEL_W-1:0] medicina;
  } niveles_t;

  // Candidate state from the levels; the most urgent need wins.
  function automatic estado_t candidato(input niveles_t n);
    if (n.medicina <= NIVEL_BAJO)      return ENFERMO;
    else if (n.energia <= NIVEL_BAJO)  return HAMBRIENTO;
    else if (n.descanso <= NIVEL_BAJO) return CANSADO;
    else if (n.animo <= NIVEL_BAJO)    return TRISTE;
    else                               return FELIZ;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/control_estados_contador_permanencia.sv
// Saturating persistence counter with clear / restart / enable.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : force the count to 0 (no limit hit possible)
//   reinicio   : count from 0 instead of the held value this cycle
//   en         : increment this cycle
//   umbral     : threshold compared against the next count
//   limite_c   : next count reaches umbral; the count clears on that edge
module control_estados_contador_permanencia #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         reinicio,
  input  logic         en,
  input  logic [W-1:0] umbral,
  output logic         limite_c
);

  logic [W-1:0] cuenta_q;
  logic [W-1:0] base;
  logic [W-1:0] cuenta_d;

  // Next count and threshold detection; saturates at all-ones.
  always_comb begin
    base     = reinicio ? '0 : cuenta_q;
    cuenta_d = base;
    limite_c = 1'b0;
    if (clr) begin
      cuenta_d = '0;
    end else if (en) begin
      if (base != '1) cuenta_d = base + W'(1);
      limite_c = (cuenta_d >= umbral);
    end
  end

  // Count register; a threshold hit consumes the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cuenta_q <= '0;
    else        cuenta_q <= limite_c ? '0 : cuenta_d;
  end

endmodule

// File: rtl/control_estados.sv
// Pet-state controller: turns the four need levels into a debounced global
// state, detects death and drives the feeding / medicine enables.
//   clk, reset        : clock, asynchronous active-low reset
//   test              : single-cycle pulse toggling the short dwell mode
//   nivel_*           : need levels 0..3 (3 = full)
//   estado            : current state code (FELIZ..MUERTO)
//   activo_comida     : enables the feeding mode button
//   activo_medicina   : enables the medicine mode button
//   modo_test         : short dwell mode active
module control_estados
  import control_estados_pkg::*;
#(
  parameter int unsigned DWELL      = 50_000_000,
  parameter int unsigned DWELL_TEST = 5_000_000,
  parameter int unsigned T_MUERTE   = 250_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                test,
  input  logic [NIVEL_W-1:0]  nivel_animo,
  input  logic [NIVEL_W-1:0]  nivel_energia,
  input  logic [NIVEL_W-1:0]  nivel_descanso,
  input  logic [NIVEL_W-1:0]  nivel_medicina,
  output logic [ESTADO_W-1:0] estado,
  output logic                activo_comida,
  output logic                activo_medicina,
  output logic                modo_test
);

  localparam int unsigned CNT_MAX = max3(DWELL, DWELL_TEST, T_MUERTE);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  niveles_t         niveles;
  estado_t          cand;
  estado_t          cand_prev_q;
  estado_t          estado_q;
  estado_t          estado_d;
  logic             muerto;
  logic             ambos_cero;
  logic             muerte_clr;
  logic             muerte_hit;
  logic             perm_clr;
  logic             perm_reinicio;
  logic             perm_hit;
  logic [CNT_W-1:0] umbral_perm;
  logic             modo_test_d;
  logic             activo_comida_d;
  logic             activo_medicina_d;

  assign niveles = {nivel_animo, nivel_energia, nivel_descanso, nivel_medicina};
  assign cand    = candidato(niveles);
  assign muerto  = (estado_q == MUERTO);

  // Death watch: both energia and medicina empty, frozen once dead.
  assign ambos_cero = (nivel_energia == NIVEL_CERO) && (nivel_medicina == NIVEL_CERO);
  assign muerte_clr = muerto || !ambos_cero;

  // Dwell: counts while a stable candidate differs from the current state;
  // a new candidate restarts the count at 1.
  assign perm_clr      = muerto || muerte_hit || (cand == estado_q);
  assign perm_reinicio = (cand != cand_prev_q);
  assign umbral_perm   = modo_test ? CNT_W'(DWELL_TEST) : CNT_W'(DWELL);

  control_estados_contador_permanencia #(.W(CNT_W)) u_permanencia (
    .clk      (clk),
    .reset    (reset),
    .clr      (perm_clr),
    .reinicio (perm_reinicio),
    .en       (1'b1),
    .umbral   (umbral_perm),
    .limite_c (perm_hit)
  );

  control_estados_contador_permanencia #(.W(CNT_W)) u_muerte (
    .clk      (clk),
    .reset    (reset),
    .clr      (muerte_clr),
    .reinicio (1'b0),
    .en       (1'b1),
    .umbral   (CNT_W'(T_MUERTE)),
    .limite_c (muerte_hit)
  );

  // Next state, test-mode toggle and enables; death beats dwell.
  always_comb begin
    estado_d    = estado_q;
    modo_test_d = modo_test;
    if (!muerto) begin
      if (muerte_hit)    estado_d = MUERTO;
      else if (perm_hit) estado_d = cand;
      if (test && !muerte_hit) modo_test_d = !modo_test;
    end
    activo_comida_d   = (estado_d != MUERTO) && (nivel_energia != NIVEL_LLENO);
    activo_medicina_d = (estado_d == ENFERMO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q        <= FELIZ;
      cand_prev_q     <= FELIZ;
      modo_test       <= 1'b0;
      activo_comida   <= 1'b0;
      activo_medicina <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      cand_prev_q     <= cand;
      modo_test       <= modo_test_d;
      activo_comida   <= activo_comida_d;
      activo_medicina <= activo_medicina_d;
    end
  end

  assign estado = ESTADO_W'(estado_q);

endmodule

// File: doc/control_estados.md
# control_estados

Pet-state controller for the virtual-pet design. It watches the four 2-bit need levels (animo, energia, descanso, medicina) produced by the mode counters and decides the pet's global emotional state. It debounces state changes in time and detects death, and it drives the `activo` enables that gate the feeding and medicine modes. It sits between the modes block and the display/LED logic, and is the single owner of the `Activo_Comida` / `Activo_Medicina` signals.

## Interface
- `DWELL`, 50_000_000: cycles a new candidate state must persist before it is adopted (normal mode).
- `DWELL_TEST`, 5_000_000: dwell length while test mode is active.
- `T_MUERTE`, 250_000_000: cycles that energia==0 and medicina==0 must both hold before death.

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `test`, in, 1: debounced single-cycle pulse from the test button.
- `nivel_animo`, in, 2: level 0..3, where 3 = full.
- `nivel_energia`, in, 2: level 0..3.
- `nivel_descanso`, in, 2: level 0..3.
- `nivel_medicina`, in, 2: level 0..3.
- `estado`, out, 3: current pet state code.
- `activo_comida`, out, 1: enables the energia mode's button input.
- `activo_medicina`, out, 1: enables the medicina mode's button input.
- `modo_test`, out, 1: high while test mode is active.

## Operation
- **State codes:** FELIZ=0, TRISTE=1, CANSADO=2, HAMBRIENTO=3, ENFERMO=4, MUERTO=5. Codes 6 and 7 are never produced.
- **Candidate state:** computed combinationally from the levels, first match wins:
  - medicina≤1 → ENFERMO
  - energia≤1 → HAMBRIENTO
  - descanso≤1 → CANSADO
  - animo≤1 → TRISTE
  - otherwise FELIZ
- **Dwell counter:**
  - Clears whenever candidate == estado.
  - While candidate != estado and candidate equals the previous cycle's candidate, it increments.
  - If candidate changes to a different non-current value, it restarts at 1.
  - estado takes the candidate on the edge where the count reaches the active dwell limit (DWELL, or DWELL_TEST when `modo_test`=1). The counter then clears.
- **Death counter:**
  - Increments while energia==0 && medicina==0, and clears otherwise.
  - On reaching T_MUERTE, estado becomes MUERTO on that edge, bypassing the dwell logic.
  - MUERTO is sticky: only `reset` leaves it. In MUERTO both counters are held at 0, and levels and `test` are ignored.
- **Enables:**
  - `activo_comida` = (next estado != MUERTO) && (nivel_energia != 3).
  - `activo_medicina` = (next estado == ENFERMO).
- **Test mode:** a `test` pulse toggles `modo_test` when not in MUERTO. Switching the dwell limit does not clear the dwell counter. If the count is already ≥ the new limit, the transition fires on the next edge.
- **Reset:** when asserted, the block immediately returns to estado=FELIZ, `activo_comida`=0, `activo_medicina`=0, `modo_test`=0, and all counters 0. Reset is asynchronous and may occur mid-dwell or in MUERTO.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Level change to `estado` update: DWELL (or DWELL_TEST) cycles after the first cycle the new candidate is sampled. An input change reverting before the limit produces no output change.
- Death: `estado`=MUERTO on the T_MUERTE-th consecutive sampled cycle with both levels at 0.
- `activo_*` update in the same cycle as `estado`. `activo_comida` additionally follows `nivel_energia` with a 1-cycle latency.
- `test` to `modo_test` toggle: 1 cycle.
- Counters are sized with $clog2 of the largest parameter. They saturate and never wrap.
- Simultaneous events:
  - Death threshold and dwell completion on the same edge: MUERTO wins.
  - A `test` pulse on the death edge is ignored.

## Structure
- Shared header `estados_mascota.vh` holds:
  - the state-code localparams (FELIZ..MUERTO);
  - the state width (3);
  - the level width (2) and the full-level constant (3).
- The modes block and the display logic include the same header.
- One natural sub-module, `contador_permanencia`: a parameterised saturating counter with clear/enable and a `limite` compare output. It is instantiated twice, once for dwell and once for death.

## Test plan
Simulation parameters are DWELL=4, DWELL_TEST=2, T_MUERTE=8.

1. Release reset with all levels 3 → `estado`=0, `activo_comida`=0, `activo_medicina`=0, `modo_test`=0. These hold for 20 cycles.
2. Set energia=1 (others 3) → `estado`=3 and `activo_comida`=1 exactly 4 cycles later. Set energia=3 for 3 cycles then back to 1 → no return to FELIZ.
3. Set energia=1 and medicina=0 together → `estado`=4 (ENFERMO priority) with `activo_medicina`=1 after 4 cycles.
4. Pulse `test` → `modo_test`=1 next cycle. Then set animo=0 → `estado`=1 after 2 cycles. Pulse `test` again → `modo_test`=0.
5. Hold energia=0 and medicina=0 → `estado`=5 on the 8th cycle, with both `activo` outputs 0. Then restore all levels to 3 and pulse `test` → still 5 and `modo_test` unchanged. Assert `reset` → `estado`=0 immediately.
6. Assert `reset` asynchronously 2 cycles into a dwell, then release → `estado`=0. The transition needs a full 4 new cycles.
